// File: rtl/fp_pkg.sv
// Shared FP32 field widths, constants and record types for the add/sub front end
// and the downstream leading-one normalizer.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 24;          // mantissa width including the hidden bit
  localparam int FRAC_W = MAN_W - 1;
  localparam int BIAS   = 127;

  // All-ones exponent marks Inf/NaN and is also the overflow target.
  localparam logic [EXP_W-1:0] EXP_MAX   = EXP_W'(2 * BIAS + 1);
  // Any alignment distance at or above this pushes the whole mantissa out.
  localparam logic [EXP_W-1:0] SHIFT_ALL = EXP_W'(MAN_W);

  typedef struct packed {
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
  } fp32_t;

  // Pre-normalization result handed to the normalizer.
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             sticky;
    logic             zero;
    logic             exc;
    logic             ovf;
  } addpre_t;

endpackage

// File: rtl/fp32_add_align_if.sv
// Operand/result handshake bundle for fp32_add_align.
// slave is the adder side, master is the producer/consumer side.
interface fp32_add_align_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;

  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [7:0]  out_e;
  logic [23:0] out_m;
  logic        out_sticky;
  logic        out_zero;
  logic        out_exc;
  logic        out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_e, out_m,
           out_sticky, out_zero, out_exc, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_m,
           out_sticky, out_zero, out_exc, out_ovf
  );

endinterface

// File: rtl/fp_align_shifter.sv
// Combinational right shifter that aligns the smaller mantissa and reports
// whether any set bit fell off the bottom.
module fp_align_shifter
  import fp_pkg::*;
(
  input  logic [MAN_W-1:0] m,
  input  logic [EXP_W-1:0] d,
  output logic [MAN_W-1:0] q,
  output logic             sticky
);

  logic [2*MAN_W-1:0] wide;

  // Shift into a double-width field so the lower half holds exactly the lost bits.
  always_comb begin
    // NOTE: every output gets a value on every path so no latch is inferred.
    wide = {m, {MAN_W{1'b0}}} >> d;
    if (d >= SHIFT_ALL) begin
      q      = '0;
      sticky = |m;
    end else begin
      q      = wide[2*MAN_W-1:MAN_W];
      sticky = |wide[MAN_W-1:0];
    end
  end

endmodule

// File: rtl/fp32_add_align.sv
// Three-stage FP32 add/sub front end: unpack/order, align, add/sub with carry fix.
// Produces the unnormalized exponent/mantissa pair for the leading-one normalizer.
module fp32_add_align
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fp32_add_align_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Flow control: a stage loads when it is empty or its content moves on.
  // ---------------------------------------------------------------------------
  logic v1, v2, v3;
  logic load1, load2, load3;

  assign load3        = !v3 || bus.out_ready;
  assign load2        = !v2 || load3;
  assign load1        = !v1 || load2;
  assign bus.in_ready = load1;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, flush denormals to zero, order by magnitude.
  // ---------------------------------------------------------------------------
  fp32_t            op_a, op_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             sign_b_eff;
  logic             swap;
  logic             exc_in;

  assign op_a       = fp32_t'(bus.in_a);
  assign op_b       = fp32_t'(bus.in_b);
  assign man_a      = (op_a.e == '0) ? '0 : {1'b1, op_a.f};
  assign man_b      = (op_b.e == '0) ? '0 : {1'b1, op_b.f};
  assign sign_b_eff = op_b.s ^ bus.in_sub;
  // Ties keep A as the larger operand.
  assign swap       = {op_b.e, man_b} > {op_a.e, man_a};
  assign exc_in     = (op_a.e == EXP_MAX) || (op_b.e == EXP_MAX);

  logic             s1_sign, s1_eff_sub, s1_exc;
  logic [EXP_W-1:0] s1_e, s1_d;
  logic [MAN_W-1:0] s1_ml, s1_ms;

  // Stage 1 register: larger operand in L, exponent distance in d.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset along with the valid bits so every
    //       output reads a defined 0 after reset, not just out_valid.
    if (!rst_n) begin
      v1         <= 1'b0;
      s1_sign    <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_exc     <= 1'b0;
      s1_e       <= '0;
      s1_d       <= '0;
      s1_ml      <= '0;
      s1_ms      <= '0;
    end else if (load1) begin
      // NOTE: non-blocking assignments keep every register sampling the
      //       pre-edge values, independent of statement order.
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1_eff_sub <= op_a.s ^ sign_b_eff;
        s1_exc     <= exc_in;
        if (swap) begin
          s1_sign <= sign_b_eff;
          s1_e    <= op_b.e;
          s1_d    <= op_b.e - op_a.e;
          s1_ml   <= man_b;
          s1_ms   <= man_a;
        end else begin
          s1_sign <= op_a.s;
          s1_e    <= op_a.e;
          s1_d    <= op_a.e - op_b.e;
          s1_ml   <= man_a;
          s1_ms   <= man_b;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align the smaller mantissa.
  // ---------------------------------------------------------------------------
  logic [MAN_W-1:0] align_m;
  logic             align_sticky;

  fp_align_shifter u_shift (
    .m      (s1_ms),
    .d      (s1_d),
    .q      (align_m),
    .sticky (align_sticky)
  );

  logic             s2_sign, s2_eff_sub, s2_exc, s2_sticky;
  logic [EXP_W-1:0] s2_e;
  logic [MAN_W-1:0] s2_ml, s2_ms;

  // Stage 2 register: aligned operands plus the shifted-out sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2         <= 1'b0;
      s2_sign    <= 1'b0;
      s2_eff_sub <= 1'b0;
      s2_exc     <= 1'b0;
      s2_sticky  <= 1'b0;
      s2_e       <= '0;
      s2_ml      <= '0;
      s2_ms      <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign    <= s1_sign;
        s2_eff_sub <= s1_eff_sub;
        s2_exc     <= s1_exc;
        s2_sticky  <= align_sticky;
        s2_e       <= s1_e;
        s2_ml      <= s1_ml;
        s2_ms      <= align_m;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: add/subtract, fold the carry back into 24 bits, flag zero/ovf.
  // ---------------------------------------------------------------------------
  logic [MAN_W:0] sum;
  addpre_t        res_next;
  addpre_t        res;

  // Magnitude ordering in stage 1 keeps the difference non-negative.
  always_comb begin
    sum = s2_eff_sub ? ({1'b0, s2_ml} - {1'b0, s2_ms})
                     : ({1'b0, s2_ml} + {1'b0, s2_ms});
    res_next        = '0;
    res_next.s      = s2_sign;
    res_next.exc    = s2_exc;
    if (sum[MAN_W]) begin
      res_next.m      = sum[MAN_W:1];
      res_next.e      = s2_e + 1'b1;
      res_next.sticky = s2_sticky | sum[0];
      res_next.ovf    = (s2_e == EXP_MAX - 1'b1);
    end else begin
      res_next.m      = sum[MAN_W-1:0];
      res_next.e      = s2_e;
      res_next.sticky = s2_sticky;
    end
    if (res_next.m == '0) begin
      res_next.zero = 1'b1;
      res_next.s    = 1'b0;
      res_next.e    = '0;
    end
  end

  // Stage 3 register: holds the result stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      res <= '0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        res <= res_next;
      end
    end
  end

  assign bus.out_valid  = v3;
  assign bus.out_s      = res.s;
  assign bus.out_e      = res.e;
  assign bus.out_m      = res.m;
  assign bus.out_sticky = res.sticky;
  assign bus.out_zero   = res.zero;
  assign bus.out_exc    = res.exc;
  assign bus.out_ovf    = res.ovf;

endmodule

// File: tb/tb_fp32_add_align.sv
// Scoreboard bench for fp32_add_align: the driver pushes expected results,
// an independent monitor pops and compares whenever a result is taken.
module tb_fp32_add_align;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp32_add_align_if bus ();

  fp32_add_align dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int      errors = 0;
  int      checks = 0;
  addpre_t exp_q[$];
  int      ready_mode = 0;  // 0: always ready, 1: stalled, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic addpre_t mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                 input logic st, input logic z, input logic x, input logic o);
    addpre_t r;
    r = '{s: s, e: e, m: m, sticky: st, zero: z, exc: x, ovf: o};
    return r;
  endfunction

  // Reference: real-number style add of two flushed FP32 magnitudes, truncated
  // to a 24-bit mantissa window with a sticky for everything discarded.
  function automatic addpre_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint  ea, eb, ma, mb, el, es, ml, ms, d, al, sum, e;
    bit      sa, sb, sl, eff, st, ovf;
    addpre_t r;
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    ma = (ea == 0) ? 0 : (64'd1 << 23) + longint'(a[22:0]);
    mb = (eb == 0) ? 0 : (64'd1 << 23) + longint'(b[22:0]);
    sa = a[31];
    sb = b[31] ^ sub;
    if (eb * 16777216 + mb > ea * 16777216 + ma) begin
      el = eb; ml = mb; es = ea; ms = ma; sl = sb;
    end else begin
      el = ea; ml = ma; es = eb; ms = mb; sl = sa;
    end
    eff = sa ^ sb;
    d   = el - es;
    if (d >= 24) begin
      al = 0;
      st = (ms != 0);
    end else begin
      al = ms / (64'd1 << d);
      st = (ms % (64'd1 << d)) != 0;
    end
    sum = eff ? ml - al : ml + al;
    e   = el;
    ovf = 1'b0;
    if (sum >= 16777216) begin
      st  = st | (sum % 2 == 1);
      sum = sum / 2;
      e   = el + 1;
      ovf = (e == 255);
    end
    r = mk(sl, 8'(e), 24'(sum), st, 1'b0, (ea == 255) || (eb == 255), ovf);
    if (sum == 0) begin
      r.zero = 1'b1;
      r.s    = 1'b0;
      r.e    = '0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    int unsigned r;
    logic [7:0]  e;
    r = $urandom_range(0, 19);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else if (r == 2) e = 8'd254;
    else             e = 8'($urandom_range(110, 140));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Single driver of out_ready; changes just after the active edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare taken results, and check stalled outputs stay frozen.
  logic        stalled = 1'b0;
  logic [37:0] held;
  always @(negedge clk) begin
    addpre_t act;
    addpre_t expv;
    act = '{s: bus.out_s, e: bus.out_e, m: bus.out_m, sticky: bus.out_sticky,
            zero: bus.out_zero, exc: bus.out_exc, ovf: bus.out_ovf};
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold_stable", {bus.out_valid, act}, held);
      stalled = 1'b0;
      if (bus.out_valid) begin
        if (!bus.out_ready) begin
          stalled = 1'b1;
          held    = {1'b1, act};
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected no result at %0t", act, $time);
        end else begin
          expv = exp_q.pop_front();
          if (expv.exc) check("result_exc", 64'(bus.out_exc), 64'(expv.exc));
          else          check("result", 64'(act), 64'(expv));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input addpre_t expv);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (i >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        bus.in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
  endtask

  logic [31:0] bp_a[5], bp_b[5];
  logic        bp_sub[5];
  int          acc;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_sub   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'({bus.out_s, bus.out_e, bus.out_m, bus.out_sticky,
                               bus.out_zero, bus.out_exc, bus.out_ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Directed cases with hand-derived results.
    send(32'h3F800000, 32'h3F800000, 1'b0, mk(0, 8'h80, 24'h800000, 0, 0, 0, 0));
    send(32'h3FC00000, 32'h3F800000, 1'b1, mk(0, 8'h7F, 24'h400000, 0, 0, 0, 0));
    send(32'h4B800000, 32'h3F800000, 1'b0, mk(0, 8'h97, 24'h800000, 1, 0, 0, 0));
    send(32'h40400000, 32'h40400000, 1'b1, mk(0, 8'h00, 24'h000000, 0, 1, 0, 0));
    send(32'h3F800000, 32'h40000000, 1'b1, mk(1, 8'h80, 24'h400000, 0, 0, 0, 0));
    send(32'h3F800001, 32'h3F800000, 1'b0, mk(0, 8'h80, 24'h800000, 1, 0, 0, 0));
    send(32'h7F000000, 32'h7F000000, 1'b0, mk(0, 8'hFF, 24'h800000, 0, 0, 0, 1));
    send(32'h00000000, 32'h80000000, 1'b0, mk(0, 8'h00, 24'h000000, 0, 1, 0, 0));
    send(32'h7F800000, 32'h3F800000, 1'b0, mk(0, 8'h00, 24'h000000, 0, 0, 1, 0));
    wait_drain();

    // Backpressure: five offered with the output stalled.
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bp_a[i]   = rand_fp();
      bp_b[i]   = rand_fp();
      bp_sub[i] = 1'($urandom);
    end
    acc          = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = bp_a[0];
    bus.in_b     = bp_b[0];
    bus.in_sub   = bp_sub[0];
    for (int cyc = 0; cyc < 60 && acc < 5; cyc++) begin
      if (cyc == 8) begin
        check("bp_accepts", 64'(acc), 64'd3);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        ready_mode = 0;
      end
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(ref_model(bp_a[acc], bp_b[acc], bp_sub[acc]));
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc < 5) begin
        bus.in_a   = bp_a[acc];
        bus.in_b   = bp_b[acc];
        bus.in_sub = bp_sub[acc];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_all_accepted", 64'(acc), 64'd5);
    wait_drain();

    // Reset with two operations in flight: neither may ever appear.
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h3F800000;
    bus.in_b     = 32'h40000000;
    bus.in_sub   = 1'b0;
    @(negedge clk);
    check("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_a = 32'h40400000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_out_m", 64'(bus.out_m), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_in_ready_after", 64'(bus.in_ready), 64'd1);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    check("rstmid_no_ghost", 64'(bus.out_valid), 64'd0);

    // Randomized traffic with random output stalls.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      logic        sub;
      a   = rand_fp();
      b   = ($urandom_range(0, 7) == 0) ? a : rand_fp();
      sub = 1'($urandom);
      send(a, b, sub, ref_model(a, b, sub));
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    wait_drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
